mul_result_checker: RTL
=======================

Name: mul_result_checker

Overview:
- Sits directly downstream of the dual IEEE754 single-precision multiplier wrapper (Verilog core plus VHDL core).
- Consumes the wrapper's two-beat result stream: `done` rises with the first core's result on `res`, and the second core's result follows on the next cycle with `done` still high.
- Captures both results and compares them, with IEEE754-aware equivalence rules.
- Reports a per-operation verdict and keeps running test and mismatch counters for self-checking the two implementations against each other.

Parameters:
- CNT_W, 16, width of the test and error counters.
- NAN_EQUAL, 1, when 1 any two NaNs compare equal regardless of sign and payload.
- ZERO_EQUAL, 0, when 1 +0 and -0 compare equal.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- done_in  in  1  upstream done flag.
- res_in  in  32  upstream result bus (first beat is result A, second beat is result B).
- clear  in  1  synchronous clear of counters and sticky flags.
- cmp_valid  out  1  one-cycle pulse; verdict outputs are valid in this cycle.
- match  out  1  verdict; 1 means A is equivalent to B.
- res_a  out  32  captured first-beat result.
- res_b  out  32  captured second-beat result.
- n_tests  out  CNT_W  count of completed comparisons; saturating.
- n_errors  out  CNT_W  count of mismatches; saturating.
- proto_err  out  1  sticky flag; set on a handshake violation.

Behaviour:
- Reset: clk and rst as stated; reset is asynchronous and active-high. On reset every output is 0, the state is IDLE and the edge register done_q is 0.
- Edge detect: `rise = done_in & ~done_q`. done_q <= done_in on every cycle.
- State IDLE:
  - On rise, capture res_in into res_a and go to CAP_B.
  - Otherwise stay in IDLE.
- State CAP_B:
  - If done_in=1, capture res_in into res_b and go to CMP.
  - If done_in=0, set proto_err, leave res_b unchanged, count nothing, and go to IDLE.
- State CMP:
  - Register match from res_a and res_b.
  - Pulse cmp_valid=1 for exactly one cycle.
  - n_tests += 1; n_errors += 1 if the result is a mismatch.
  - Go to IDLE.
- Latency: if T is the cycle in which done_in first reads 1, res_a is captured at the end of T and res_b at the end of T+1. cmp_valid and match are high during T+3. match, res_a and res_b hold their values until the next comparison.
- Equivalence rules (match=1), evaluated in this order:
  - Bitwise equal.
  - NAN_EQUAL=1 and both operands are NaN (exponent=8'hFF and mantissa≠0).
  - ZERO_EQUAL=1 and bits[30:0]==0 for both operands.
  - Otherwise match=0.
- Infinities: ±Inf compare bitwise only.
- Counters: saturate at all-ones and never wrap.
- clear:
  - Clear has priority over a same-cycle increment: counters go to 0 and proto_err goes to 0.
  - The FSM and the captured data are unaffected.
  - A cmp_valid pulse coincident with clear still pulses, but its counts are discarded.
- done_in held high across more than 2 cycles: no new rise occurs, so the block ignores it after capture.
- A rise seen while in CMP is a violation: set proto_err, finish the comparison normally, and do not start a new capture. The upstream minimum cycle time makes this illegal.
- Reset mid-operation: returns the block immediately to IDLE with all outputs at 0. Any partial capture is discarded.

Test Plan:
- Equal results: done_in high for 2 cycles, res_in=32'h40490FDB then 32'h40490FDB -> cmp_valid pulse at T+3, match=1, n_tests=1, n_errors=0.
- Mismatch: beats 32'h3F800000 then 32'h3F800001 -> match=0, n_errors=1, res_a=32'h3F800000, res_b=32'h3F800001.
- NaN rule: beats 32'h7FC00000 then 32'hFFC00001 -> match=1 with NAN_EQUAL=1; same beats with NAN_EQUAL=0 -> match=0.
- Signed zero: beats 32'h00000000 then 32'h80000000 -> match=0 with ZERO_EQUAL=0; match=1 with ZERO_EQUAL=1.
- Protocol error: done_in high for 1 cycle only -> proto_err=1, no cmp_valid, n_tests unchanged. Then assert clear -> proto_err=0 and counters=0.
- Saturation and reset:
  - With CNT_W=2, run 5 mismatching operations -> n_tests=3 and n_errors=3.
  - Assert rst in the CAP_B cycle -> all outputs=0, and the next valid two-beat sequence compares normally.

Source files
------------

// File: rtl/mul_result_checker.sv
// Cross-checks the two results of the dual IEEE754 multiplier wrapper.
// Captures the two-beat result stream, compares A against B, and counts tests and mismatches.
module mul_result_checker #(
    parameter int CNT_W      = 16,
    parameter bit NAN_EQUAL  = 1'b1,
    parameter bit ZERO_EQUAL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done_in,
    input  logic [31:0]      res_in,
    input  logic             clear,
    output logic             cmp_valid,
    output logic             match,
    output logic [31:0]      res_a,
    output logic [31:0]      res_b,
    output logic [CNT_W-1:0] n_tests,
    output logic [CNT_W-1:0] n_errors,
    output logic             proto_err
);

    typedef enum logic [1:0] {IDLE, CAP_B, CMP} state_t;

    state_t state;
    logic   done_q;
    logic   rise;
    logic   equiv;
    logic   proto_set;
    logic   inc_tests;
    logic   inc_errors;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    assign rise = done_in & ~done_q;

    // Rules are ordered: exact bits first, then the optional NaN and signed-zero relaxations.
    always_comb begin
        equiv = 1'b0;
        if (res_a == res_b)
            equiv = 1'b1;
        else if (NAN_EQUAL && is_nan(res_a) && is_nan(res_b))
            equiv = 1'b1;
        else if (ZERO_EQUAL && (res_a[30:0] == 31'd0) && (res_b[30:0] == 31'd0))
            equiv = 1'b1;
    end

    assign proto_set  = ((state == CAP_B) && !done_in) || ((state == CMP) && rise);
    assign inc_tests  = (state == CMP);
    assign inc_errors = (state == CMP) && !equiv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            cmp_valid <= 1'b0;
            match     <= 1'b0;
            res_a     <= 32'd0;
            res_b     <= 32'd0;
            n_tests   <= '0;
            n_errors  <= '0;
            proto_err <= 1'b0;
        end else begin
            done_q    <= done_in;
            cmp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        res_a <= res_in;
                        state <= CAP_B;
                    end
                end
                CAP_B: begin
                    if (done_in) begin
                        res_b <= res_in;
                        state <= CMP;
                    end else begin
                        state <= IDLE;
                    end
                end
                CMP: begin
                    match     <= equiv;
                    cmp_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Clear wins over any same-cycle increment or violation.
            if (clear) begin
                n_tests   <= '0;
                n_errors  <= '0;
                proto_err <= 1'b0;
            end else begin
                if (proto_set)
                    proto_err <= 1'b1;
                if (inc_tests && (n_tests != '1))
                    n_tests <= n_tests + CNT_W'(1);
                if (inc_errors && (n_errors != '1))
                    n_errors <= n_errors + CNT_W'(1);
            end
        end
    end

endmodule
